// File: rtl/mavg_pkg.sv
// Shared constants for the 3-tap moving-sum filter and its inverse.
package mavg_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = 10;
  localparam int TAPS       = 3;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_HI = sat_hi(DATA_W_DEF);
  localparam int SAT_LO = sat_lo(DATA_W_DEF);

endpackage

// File: rtl/mavg_out_stage.sv
// Single output register with valid/ready hold; accepts a new word whenever
// the register is empty or being drained this cycle.
module mavg_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  input  logic         rdy_i,
  output logic [W-1:0] q_o,
  output logic         vld_o,
  output logic         can_ld_o
);

  logic [W-1:0] q_q, q_d;
  logic         vld_q, vld_d;

  assign can_ld_o = !vld_q || rdy_i;

  always_comb begin
    q_d   = q_q;
    vld_d = vld_q;
    if (ld_i) begin
      q_d   = d_i;
      vld_d = 1'b1;
    end else if (rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/moving_avg_inv.sv
// Inverse 3-tap moving-sum: x[n] = s[n] - x[n-1] - x[n-2], valid/ready output.
// MOVING_AVG_INV_SAT_EN: saturate out-of-range samples instead of wrapping.
module moving_avg_inv
  import mavg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resync,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] num_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic [7:0]        ovf_cnt
);

  localparam int XW = SUM_W + 1 - DATA_W;

  logic [0:0]              st_q, st_d;
  logic [DATA_W-1:0]       h1_q, h1_d, h2_q, h2_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [SUM_W:0]   d;
  logic [DATA_W-1:0]       x;
  logic                    ovr, acc, can_ld;

  // One extra bit keeps sum - h1 - h2 exact for any legal operands.
  assign d = $signed({sum_in[SUM_W-1], sum_in})
           - $signed({{XW{h1_q[DATA_W-1]}}, h1_q})
           - $signed({{XW{h2_q[DATA_W-1]}}, h2_q});

  assign ovr = (int'(d) > sat_hi(DATA_W)) || (int'(d) < sat_lo(DATA_W));

`ifdef MOVING_AVG_INV_SAT_EN
  assign x = !ovr     ? d[DATA_W-1:0] :
             d[SUM_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                        {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign x = d[DATA_W-1:0];
`endif

  assign in_ready = (st_q == ST_RUN) && !resync && can_ld;
  assign acc      = in_valid && in_ready;

  always_comb begin
    st_d  = st_q;
    h1_d  = h1_q;
    h2_d  = h2_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (resync) begin
      st_d  = ST_FLUSH;
      h1_d  = '0;
      h2_d  = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (st_q == ST_FLUSH && !(out_valid && !out_ready)) st_d = ST_RUN;
      if (acc) begin
        // History tracks the emitted value so the encoder and decoder stay aligned.
        h2_d = h1_q;
        h1_d = x;
        if (ovr) begin
          ovf_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_RUN;
      h1_q  <= '0;
      h2_q  <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      h1_q  <= h1_d;
      h2_q  <= h2_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  mavg_out_stage #(.W(DATA_W)) u_out (
    .clk      (clk),
    .rst_n    (rst),
    .ld_i     (acc),
    .d_i      (x),
    .rdy_i    (out_ready),
    .q_o      (num_out),
    .vld_o    (out_valid),
    .can_ld_o (can_ld)
  );

  assign ovf     = ovf_q;
  assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_moving_avg_inv.sv
// Bench for moving_avg_inv: table-driven round trip plus directed corner sequences.
module tb_moving_avg_inv;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       resync = 1'b0;
  logic [9:0] sum_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] num_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       ovf;
  logic [7:0] ovf_cnt;

  always #5 clk = ~clk;

  moving_avg_inv dut (
    .clk       (clk),
    .rst       (rst),
    .resync    (resync),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_out   (num_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_cnt   (ovf_cnt)
  );

`ifdef MOVING_AVG_INV_SAT_EN
  localparam int OV1 = 127;  // 300 from zero history
  localparam int OV2 = 127;  // 300 with h1=9, h2=0
`else
  localparam int OV1 = 44;
  localparam int OV2 = 35;
`endif

  typedef struct {int s; int e;} vec_t;
  vec_t tv[5];

  int         ntest = 0;
  int         nfail = 0;
  logic [7:0] cur_exp = '0;
  logic [7:0] e_pop;
  logic [7:0] q[$];
  int         m1, m2;

  task automatic chk(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference recurrence for the long overflow run.
  function automatic int mdl(input int s);
    int d, x;
    d = s - m1 - m2;
    if (d > 127 || d < -128) begin
`ifdef MOVING_AVG_INV_SAT_EN
      x = (d > 0) ? 127 : -128;
`else
      x = d & 255;
      if (x > 127) x -= 256;
`endif
    end else x = d;
    m2 = m1;
    m1 = x;
    return x;
  endfunction

  // Scoreboard: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (rst && in_valid && in_ready) q.push_back(cur_exp);
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        ntest++;
        nfail++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(num_out));
      end else begin
        e_pop = q.pop_front();
        chk("data", $signed(num_out), $signed(e_pop));
      end
    end
  end

  task automatic send(input int s, input int e);
    bit ok;
    ok = 1'b0;
    sum_in = 10'(s);
    cur_exp = 8'(e);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      ntest++;
      nfail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (sum %0d)", s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      ntest++;
      nfail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    resync = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sum_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m1 = 0;
    m2 = 0;
  endtask

  task automatic pulse_resync();
    @(posedge clk); #1;
    resync = 1'b1;
    @(negedge clk);
    chk("resync_in_ready", in_ready, 0);
    @(posedge clk); #1;
    resync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{5, 5};
    tv[1] = '{2, -3};
    tv[2] = '{9, 7};
    tv[3] = '{104, 100};
    tv[4] = '{-21, -128};

    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_num_out", num_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Round trip with one-cycle latency
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send(tv[i].s, tv[i].e);
      chk("latency", out_valid ? int'($signed(num_out)) : 999, tv[i].e);
    end
    drain();
    chk("roundtrip_ovf", ovf, 0);

    // Backpressure: hold the first output for three cycles
    do_reset();
    send(5, 5);
    out_ready = 1'b0;
    fork
      begin
        send(2, -3);
        send(9, 7);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("hold_num_out", $signed(num_out), 5);
          chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Overflow from zero history, then prove h1 holds the emitted value
    do_reset();
    send(300, OV1);
    chk("ovf_num_out", $signed(num_out), OV1);
    chk("ovf_flag", ovf, 1);
    chk("ovf_cnt_1", ovf_cnt, 1);
    send(OV1, 0);
    drain();

    // Resync with nothing pending: one FLUSH cycle, counters cleared
    pulse_resync();
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("resync_ovf", ovf, 0);
    chk("resync_ovf_cnt", ovf_cnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Resync while an output is pending
    send(5, 5);
    send(2, -3);
    out_ready = 1'b0;
    pulse_resync();
    repeat (2) begin
      @(negedge clk);
      chk("flush_hold_rdy", in_ready, 0);
      chk("flush_hold_val", out_valid ? int'($signed(num_out)) : 999, -3);
      chk("flush_ovf_cnt", ovf_cnt, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_last_rdy", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_exit_rdy", in_ready, 1);
    @(posedge clk); #1;
    send(9, 9);
    drain();

    // Asynchronous reset between edges
    @(posedge clk); #1;
    send(300, OV2);
    chk("pre_rst_ovf", ovf, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_num_out", num_out, 0);
    chk("arst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    send(5, 5);
    drain();

    // Overflow counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send(500, mdl(500));
    drain();
    chk("sat_ovf_cnt", ovf_cnt, 255);
    chk("sat_ovf", ovf, 1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
